// File: rtl/rsa_mem_pkg.sv
// Shared types and defaults for the RSA data-memory arbitration slice.
package rsa_mem_pkg;

  localparam int DEF_ARQ              = 16;
  localparam int DEF_MEMORY_ADDR_SIZE = 13;
  localparam int DEF_STARVE_LIMIT     = 8;

  // Owner of the read that returns data in the current cycle.
  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_PIPE = 2'd1,
    RD_HOST = 2'd2
  } rd_owner_t;

  // Which requester owns the memory port in the current cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PIPE = 2'd1,
    GNT_HOST = 2'd2
  } gnt_sel_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive cycles the host has been denied the memory.
// at_limit tells the arbiter that the host must be forced in this cycle.
import rsa_mem_pkg::*;

module arb_starve_counter #(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt;

  // Clear wins over increment; the count holds once it reaches the limit.
  // NOTE: state is written with non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != LIMIT)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign at_limit = (cnt == LIMIT);

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-port data memory between the MEM pipeline stage and the
// host/loader port. The pipeline wins by default; a host that has waited
// STARVE_LIMIT cycles is forced in and the pipeline is stalled for that cycle.
// Read data returns one cycle later, tagged to whichever side issued the read.
import rsa_mem_pkg::*;

module data_mem_arbiter #(
  parameter int ARQ              = DEF_ARQ,
  parameter int MEMORY_ADDR_SIZE = DEF_MEMORY_ADDR_SIZE,
  parameter int STARVE_LIMIT     = DEF_STARVE_LIMIT
) (
  input  logic                        clk,
  input  logic                        rst,
  // MEM-stage port
  input  logic                        pipe_rd_en,
  input  logic                        pipe_wr_en,
  input  logic [MEMORY_ADDR_SIZE-1:0] pipe_addr,
  input  logic [ARQ-1:0]              pipe_wdata,
  output logic                        pipe_stall,
  output logic                        pipe_rvalid,
  output logic [ARQ-1:0]              pipe_rdata,
  // Host/loader port
  input  logic                        host_req,
  input  logic                        host_we,
  input  logic [MEMORY_ADDR_SIZE-1:0] host_addr,
  input  logic [ARQ-1:0]              host_wdata,
  output logic                        host_gnt,
  output logic                        host_rvalid,
  output logic [ARQ-1:0]              host_rdata,
  // Memory macro port
  output logic [MEMORY_ADDR_SIZE-1:0] mem_addr,
  output logic [ARQ-1:0]              mem_wdata,
  output logic                        mem_we,
  output logic                        mem_re,
  input  logic [ARQ-1:0]              mem_rdata
);

  logic      pipe_act;
  logic      at_limit;
  gnt_sel_t  gnt_sel;
  rd_owner_t rd_owner;
  rd_owner_t rd_owner_next;

  // A simultaneous load and store is treated as a store.
  assign pipe_act = pipe_rd_en | pipe_wr_en;

  arb_starve_counter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .inc      (host_req & ~host_gnt),
    .clr      (host_gnt | ~host_req),
    .at_limit (at_limit)
  );

  // Grant selection: pipeline by default, host when idle pipe or starved.
  // The grant is also gated by rst so every output reads 0 while reset is held,
  // not just after the next edge.
  // NOTE: every variable driven here gets a default first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    gnt_sel = GNT_NONE;
    if (rst) begin
      if (host_req && (!pipe_act || at_limit)) begin
        gnt_sel = GNT_HOST;
      end else if (pipe_act) begin
        gnt_sel = GNT_PIPE;
      end
    end
  end

  assign host_gnt   = (gnt_sel == GNT_HOST);
  assign pipe_stall = host_gnt & pipe_act;

  // Memory mux: the granted requester drives address, data and strobes.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    unique case (gnt_sel)
      GNT_PIPE: begin
        mem_addr  = pipe_addr;
        mem_wdata = pipe_wdata;
        mem_we    = pipe_wr_en;
        mem_re    = ~pipe_wr_en;
      end
      GNT_HOST: begin
        mem_addr  = host_addr;
        mem_wdata = host_wdata;
        mem_we    = host_we;
        mem_re    = ~host_we;
      end
      default: ;
    endcase
  end

  // Next read owner: tag this cycle's granted read for next cycle's return.
  always_comb begin
    rd_owner_next = RD_NONE;
    if ((gnt_sel == GNT_PIPE) && !pipe_wr_en) begin
      rd_owner_next = RD_PIPE;
    end else if ((gnt_sel == GNT_HOST) && !host_we) begin
      rd_owner_next = RD_HOST;
    end
  end

  // Read-owner register; reset drops any read still in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_owner <= RD_NONE;
    end else begin
      rd_owner <= rd_owner_next;
    end
  end

  // Read return: steer memory data to the tagged owner, zero otherwise.
  always_comb begin
    pipe_rvalid = 1'b0;
    pipe_rdata  = '0;
    host_rvalid = 1'b0;
    host_rdata  = '0;
    unique case (rd_owner)
      RD_PIPE: begin
        pipe_rvalid = 1'b1;
        pipe_rdata  = mem_rdata;
      end
      RD_HOST: begin
        host_rvalid = 1'b1;
        host_rdata  = mem_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomised bench for data_mem_arbiter with a behavioural model of the
// grant rules, starvation wait and tagged one-cycle read return.
module tb_data_mem_arbiter;

  localparam int ARQ = 16;
  localparam int AW  = 13;
  localparam int SL  = 8;

  logic           clk;
  logic           rst;
  logic           pipe_rd_en, pipe_wr_en;
  logic [AW-1:0]  pipe_addr;
  logic [ARQ-1:0] pipe_wdata;
  logic           pipe_stall, pipe_rvalid;
  logic [ARQ-1:0] pipe_rdata;
  logic           host_req, host_we;
  logic [AW-1:0]  host_addr;
  logic [ARQ-1:0] host_wdata;
  logic           host_gnt, host_rvalid;
  logic [ARQ-1:0] host_rdata;
  logic [AW-1:0]  mem_addr;
  logic [ARQ-1:0] mem_wdata;
  logic           mem_we, mem_re;
  logic [ARQ-1:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  data_mem_arbiter #(
    .ARQ              (ARQ),
    .MEMORY_ADDR_SIZE (AW),
    .STARVE_LIMIT     (SL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pipe_rd_en  (pipe_rd_en),
    .pipe_wr_en  (pipe_wr_en),
    .pipe_addr   (pipe_addr),
    .pipe_wdata  (pipe_wdata),
    .pipe_stall  (pipe_stall),
    .pipe_rvalid (pipe_rvalid),
    .pipe_rdata  (pipe_rdata),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_gnt    (host_gnt),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_re      (mem_re),
    .mem_rdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory macro: synchronous single port, data one cycle after mem_re.
  logic [ARQ-1:0] mem_array [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_we) mem_array[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem_array[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  logic [ARQ-1:0] shadow [0:(1<<AW)-1];
  int             m_wait = 0;   // consecutive cycles the host has been refused
  int             m_pend = 0;   // 0 none, 1 pipe, 2 host read returning now
  logic [ARQ-1:0] m_pend_data = '0;

  always @(negedge clk) begin
    logic           p_act, e_host, e_pipe, e_we, e_re;
    logic [AW-1:0]  e_addr;
    logic [ARQ-1:0] e_wdata;
    if (!rst) begin
      m_wait = 0;
      m_pend = 0;
      check("rst_strobes", {host_gnt, pipe_stall, mem_we, mem_re, pipe_rvalid, host_rvalid}, '0);
      check("rst_mem_bus", {mem_addr, mem_wdata}, '0);
      check("rst_rdata", {pipe_rdata, host_rdata}, '0);
    end else begin
      p_act  = pipe_rd_en || pipe_wr_en;
      e_host = host_req && (!p_act || (m_wait >= SL));
      e_pipe = p_act && !e_host;
      e_addr = '0; e_wdata = '0; e_we = 1'b0; e_re = 1'b0;
      if (e_host) begin
        e_addr = host_addr; e_wdata = host_wdata; e_we = host_we; e_re = !host_we;
      end else if (e_pipe) begin
        e_addr = pipe_addr; e_wdata = pipe_wdata; e_we = pipe_wr_en; e_re = !pipe_wr_en;
      end
      check("cmp_host_gnt", host_gnt, e_host);
      check("cmp_pipe_stall", pipe_stall, e_host && p_act);
      check("cmp_mem_addr", mem_addr, e_addr);
      check("cmp_mem_wdata", mem_wdata, e_wdata);
      check("cmp_mem_we", mem_we, e_we);
      check("cmp_mem_re", mem_re, e_re);
      check("cmp_pipe_rvalid", pipe_rvalid, m_pend == 1);
      check("cmp_pipe_rdata", pipe_rdata, (m_pend == 1) ? m_pend_data : '0);
      check("cmp_host_rvalid", host_rvalid, m_pend == 2);
      check("cmp_host_rdata", host_rdata, (m_pend == 2) ? m_pend_data : '0);
      // Advance the model to what the coming edge commits.
      if (e_host || !host_req) m_wait = 0;
      else if (m_wait < SL) m_wait = m_wait + 1;
      m_pend = 0;
      if (e_re) begin
        m_pend      = e_host ? 2 : 1;
        m_pend_data = shadow[e_addr];
      end
      if (e_we) shadow[e_addr] = e_wdata;
    end
  end

  // Pipe reads 0x10 under a held host read of 0x20 until the host is forced.
  task automatic starve_run();
    pipe_rd_en = 1'b1; pipe_wr_en = 1'b0; pipe_addr = 13'h0010;
    host_req = 1'b1; host_we = 1'b0; host_addr = 13'h0020;
    for (int i = 0; i < SL; i++) begin
      @(negedge clk);
      check("starve_deny", host_gnt, 1'b0);
      check("starve_no_stall", pipe_stall, 1'b0);
      if (i > 0) begin
        check("alt_pipe_rvalid", pipe_rvalid, 1'b1);
        check("alt_pipe_rdata", pipe_rdata, 16'h1111);
      end
      step();
    end
    @(negedge clk);
    check("forced_host_gnt", host_gnt, 1'b1);
    check("forced_stall", pipe_stall, 1'b1);
    check("forced_mem_addr", mem_addr, 13'h0020);
    check("forced_pipe_rdata", pipe_rdata, 16'h1111);
    step();
    host_req = 1'b0;
    @(negedge clk);
    check("after_force_stall", pipe_stall, 1'b0);
    check("after_force_pipe_served", {mem_re, mem_addr}, {1'b1, 13'h0010});
    check("alt_host_rvalid", host_rvalid, 1'b1);
    check("alt_host_rdata", host_rdata, 16'h2222);
    check("alt_no_cross", pipe_rvalid, 1'b0);
    step();
    pipe_rd_en = 1'b0;
    @(negedge clk);
    check("alt_pipe_back", {pipe_rvalid, pipe_rdata, host_rvalid}, {1'b1, 16'h1111, 1'b0});
    step();
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    if ($urandom_range(0, 3) == 0) a = 13'h1FFF;
    else a = AW'($urandom_range(0, 15));
    return a;
  endfunction

  initial begin
    logic g, s;
    int   rst_cnt;
    rst = 1'b0;
    pipe_rd_en = 1'b0; pipe_wr_en = 1'b0; pipe_addr = '0; pipe_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    for (int a = 0; a < (1 << AW); a++) begin
      mem_array[a] = ARQ'(a) ^ 16'hA5A5;
      shadow[a]    = ARQ'(a) ^ 16'hA5A5;
    end
    mem_array[13'h0005] = 16'h1234; shadow[13'h0005] = 16'h1234;
    mem_array[13'h0010] = 16'h1111; shadow[13'h0010] = 16'h1111;
    mem_array[13'h0020] = 16'h2222; shadow[13'h0020] = 16'h2222;

    // Reset with no requests.
    repeat (2) @(negedge clk);
    check("reset_idle", {host_gnt, pipe_stall, mem_re, mem_we, pipe_rvalid, host_rvalid}, '0);

    // Pipe read of 0x0005 granted in the first cycle out of reset.
    step();
    rst = 1'b1; pipe_rd_en = 1'b1; pipe_addr = 13'h0005;
    @(negedge clk);
    check("pipe_rd_grant", {mem_re, mem_we, mem_addr}, {1'b1, 1'b0, 13'h0005});
    step();
    pipe_rd_en = 1'b0;
    @(negedge clk);
    check("pipe_rd_return", {pipe_rvalid, pipe_rdata, host_rvalid}, {1'b1, 16'h1234, 1'b0});

    // Host write to the top address, then a pipe read of it.
    step();
    host_req = 1'b1; host_we = 1'b1; host_addr = 13'h1FFF; host_wdata = 16'h00AA;
    @(negedge clk);
    check("host_wr_grant", {host_gnt, mem_we, mem_re, mem_addr}, {1'b1, 1'b1, 1'b0, 13'h1FFF});
    step();
    host_req = 1'b0; pipe_rd_en = 1'b1; pipe_addr = 13'h1FFF;
    @(negedge clk);
    check("rd_after_wr_strobe", mem_re, 1'b1);
    step();
    pipe_rd_en = 1'b0;
    @(negedge clk);
    check("rd_after_wr_data", pipe_rdata, 16'h00AA);

    // Starvation with alternating read owners.
    step();
    starve_run();

    // Simultaneous load and store is a store with no return.
    pipe_rd_en = 1'b1; pipe_wr_en = 1'b1; pipe_addr = 13'h0030; pipe_wdata = 16'hBEEF;
    @(negedge clk);
    check("rdwr_is_write", {mem_we, mem_re, mem_wdata}, {1'b1, 1'b0, 16'hBEEF});
    step();
    pipe_rd_en = 1'b0; pipe_wr_en = 1'b0;
    @(negedge clk);
    check("rdwr_no_rvalid", pipe_rvalid, 1'b0);

    // Reset one cycle after a granted host read drops the return.
    step();
    host_req = 1'b1; host_we = 1'b0; host_addr = 13'h0020;
    @(negedge clk);
    check("pre_rst_host_gnt", host_gnt, 1'b1);
    step();
    rst = 1'b0; pipe_rd_en = 1'b1; pipe_addr = 13'h0010;
    repeat (2) begin
      @(negedge clk);
      check("rst_drop_rvalid", host_rvalid, 1'b0);
      check("rst_all_zero", {host_gnt, pipe_stall, mem_re, mem_we, host_rdata, mem_addr}, '0);
      step();
    end
    rst = 1'b1;
    starve_run();

    // Randomised traffic under the hold-until-granted / hold-while-stalled protocol.
    rst_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      g = host_gnt;
      s = pipe_stall;
      step();
      if (rst_cnt > 0) begin
        rst_cnt--;
        if (rst_cnt == 0) rst = 1'b1;
      end else if ($urandom_range(0, 399) == 0) begin
        rst = 1'b0;
        rst_cnt = $urandom_range(1, 3);
      end
      if (!(host_req && !g)) begin
        host_req   = ($urandom_range(0, 2) == 0);
        host_we    = 1'($urandom_range(0, 1));
        host_addr  = rand_addr();
        host_wdata = ARQ'($urandom);
      end
      if (!s) begin
        case ($urandom_range(0, 3))
          0:       begin pipe_rd_en = 1'b0; pipe_wr_en = 1'b0; end
          1:       begin pipe_rd_en = 1'b1; pipe_wr_en = 1'b0; end
          2:       begin pipe_rd_en = 1'b0; pipe_wr_en = 1'b1; end
          default: begin pipe_rd_en = 1'b1; pipe_wr_en = 1'b1; end
        endcase
        pipe_addr  = rand_addr();
        pipe_wdata = ARQ'($urandom);
      end
    end
    rst = 1'b1;
    pipe_rd_en = 1'b0; pipe_wr_en = 1'b0; host_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Shares the single-port data memory (2^MEMORY_ADDR_SIZE words × ARQ bits) between the MEM stage of the execution pipeline and the host/loader port, which streams RSA operands in and results out. The pipeline has default priority. A starvation counter forces a host slot after a bounded wait, and stalls the pipeline for that cycle. The block sits between the MEM stage of the EXE/MEM pipe and the data memory macro, and tags and returns read data to the correct requester.

## Interface
- ARQ, 16, data word width
- MEMORY_ADDR_SIZE, 13, word address width
- STARVE_LIMIT, 8, consecutive denied host cycles before the host is forced in (1..255)

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- pipe_rd_en  in  1  MEM-stage load request
- pipe_wr_en  in  1  MEM-stage store request
- pipe_addr  in  MEMORY_ADDR_SIZE  MEM-stage address
- pipe_wdata  in  ARQ  store data
- pipe_stall  out  1  freezes the EXE/MEM and MEM/WB registers this cycle
- pipe_rvalid  out  1  load data valid on pipe_rdata
- pipe_rdata  out  ARQ  load data
- host_req  in  1  host access request, held until granted
- host_we  in  1  1 = write, 0 = read
- host_addr  in  MEMORY_ADDR_SIZE  host address
- host_wdata  in  ARQ  host write data
- host_gnt  out  1  host access accepted this cycle
- host_rvalid  out  1  host read data valid
- host_rdata  out  ARQ  host read data
- mem_addr  out  MEMORY_ADDR_SIZE  memory address
- mem_wdata  out  ARQ  memory write data
- mem_we  out  1  memory write strobe
- mem_re  out  1  memory read strobe
- mem_rdata  in  ARQ  memory read data, valid 1 cycle after mem_re

## Operation
- pipe_act = pipe_rd_en | pipe_wr_en. If both are high, the access is a write and pipe_rd_en is ignored. No pipe_rvalid is produced.
- Grant per cycle:
  - no pipe_act, host_req → host
  - pipe_act, no host_req → pipe
  - both, starve_cnt < STARVE_LIMIT → pipe
  - both, starve_cnt == STARVE_LIMIT → host, and pipe_stall = 1
- pipe_stall is high only on a forced host cycle. The stalled pipe request must be held by the pipeline and wins the next cycle, because starve_cnt is cleared by the host grant.
- starve_cnt (width clog2(STARVE_LIMIT+1)):
  - Increments when host_req=1 and host_gnt=0.
  - Saturates at STARVE_LIMIT.
  - Clears to 0 on host_gnt or host_req=0.
- Memory mux: the granted requester's addr and wdata drive mem_addr and mem_wdata. mem_we and mem_re come from the granted request's type. With no grant, mem_we = mem_re = 0 and mem_addr/mem_wdata = 0.
- Read return FSM, state rd_owner ∈ {RD_NONE, RD_PIPE, RD_HOST}, registered each cycle from this cycle's granted read:
  - RD_PIPE → pipe_rvalid = 1, pipe_rdata = mem_rdata
  - RD_HOST → host_rvalid = 1, host_rdata = mem_rdata
  - RD_NONE → both rvalids are 0 and both rdata outputs are 0
- Back-to-back reads by alternating owners are legal, one per cycle. Each read returns to its own tag.
- A write followed by a read of the same address in the next cycle returns the new data; the memory is write-first.

## Timing
- Grant, pipe_stall and the mem_* strobes are combinational from the requests and registered state, in the same cycle.
- Read latency is 1 cycle from grant to rvalid. Writes complete at the grant edge.
- Maximum host wait is STARVE_LIMIT+1 cycles under continuous pipe traffic.
- Reset (rst=0, any time) immediately drives:
  - starve_cnt = 0, rd_owner = RD_NONE
  - all outputs 0
- An in-flight read whose rvalid is due after reset asserts is dropped; no rvalid is produced.
- First grant is possible in the first cycle with rst=1.

## Structure
- Shared package rsa_mem_pkg:
  - rd_owner_t enum {RD_NONE, RD_PIPE, RD_HOST}
  - ARQ and MEMORY_ADDR_SIZE defaults
  - DEF_STARVE_LIMIT = 8
- Sub-module arb_starve_counter: saturating counter with inc/clr inputs and an at_limit output, parameterised by STARVE_LIMIT.
- The top level holds the grant logic, the memory mux and the rd_owner register.

## Test plan
- Reset with no requests, then rst=1, pipe read of addr 0x0005 holding 0x1234 → mem_re=1 at the grant; next cycle pipe_rvalid=1, pipe_rdata=0x1234, host_rvalid=0.
- Host write of 0x00AA to 0x1FFF with the pipe idle → host_gnt=1 in the same cycle, mem_we=1, mem_addr=0x1FFF; a pipe read next cycle returns 0x00AA.
- Pipe active every cycle with host_req held (STARVE_LIMIT=8) → host_gnt=0 for 8 cycles; on the 9th host_gnt=1 and pipe_stall=1; next cycle pipe_stall=0 and the pipe request is served.
- Alternating grants: pipe read 0x0010 (=0x1111), then forced host read 0x0020 (=0x2222) → pipe_rvalid with 0x1111, then host_rvalid with 0x2222, never crossed.
- pipe_rd_en=pipe_wr_en=1 → treated as a write: mem_we=1, mem_re=0, no pipe_rvalid next cycle.
- Assert rst=0 one cycle after a granted host read → host_rvalid stays 0 and all outputs are 0; after release, starve_cnt restarts from 0.
